// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and baud tick divisor.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BRK
   } rx_state_t;

   function automatic int tick_div(input int clock_freq, input int baud_rate, input int oversample);
      return clock_freq / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: o_tick is high for one clk each time the divider wraps.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int DIV = tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(DIV - 1));
   assign o_tick = w_wrap;

   always_ff @(posedge i_clk) begin
      if (!i_rst)
         r_cnt <= '0;
      else if (w_wrap)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready byte output; 8N1 by default,
// 8E1 with the even-parity check when UART_RX_PARITY_EN is defined.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_busy,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] S_HALF   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 w_rxs;
   logic                 w_tick;
   rx_state_t            r_state;
   rx_state_t            w_state_nxt;
   logic [SW-1:0]        r_scnt;
   logic [IW-1:0]        r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 w_bit_end;
   logic                 w_sample;
   logic                 w_stop_eval;
   logic                 w_par_bad;
`ifdef UART_RX_PARITY_EN
   logic                 r_par;
   logic                 r_parity_err;
   logic                 w_par_sample;
`endif

   uart_baud_tick #(
      .CLOCK_FREQ(CLOCK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tick (
      .i_clk (clk),
      .i_rst (rst),
      .o_tick(w_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs     = r_sync2;
   assign w_bit_end = w_tick && (r_scnt == S_LAST);

   always_ff @(posedge clk) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sample    = 1'b0;
      w_stop_eval = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_sample = 1'b0;
`endif
      case (r_state)
         ST_IDLE:  if (!w_rxs) w_state_nxt = ST_START;
         // Mid-start-bit recheck rejects short glitches
         ST_START: if (w_tick && r_scnt == S_HALF) w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
         ST_DATA: begin
            if (w_bit_end) begin
               w_sample = 1'b1;
               if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (w_bit_end) begin
               w_par_sample = 1'b1;
               w_state_nxt  = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (w_bit_end) begin
               w_stop_eval = 1'b1;
               w_state_nxt = w_rxs ? ST_IDLE : ST_BRK;
            end
         end
         ST_BRK:  if (w_rxs) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_scnt <= '0;
         r_idx  <= '0;
      end else begin
         if (w_state_nxt != r_state || w_sample)
            r_scnt <= '0;
         else if (w_tick)
            r_scnt <= r_scnt + SW'(1);
         if (r_state == ST_START)
            r_idx <= '0;
         else if (w_sample)
            r_idx <= r_idx + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_sample)
         r_shift[r_idx] <= w_rxs;
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (w_par_sample)
         r_par <= w_rxs;
   end

   assign w_par_bad = (r_par != ^r_shift);
`else
   assign w_par_bad = 1'b0;
`endif

   // Holding register: a completed frame only lands when the slot is free or being emptied this clk
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         if (r_valid && rx_ready)
            r_valid <= 1'b0;
         if (w_stop_eval) begin
            if (!w_rxs) begin
               r_frame_err <= 1'b1;
            end else if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
               r_parity_err <= 1'b1;
`endif
            end else if (!r_valid || rx_ready) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign rx_busy   = (r_state != ST_IDLE);
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule
